// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: widths, trap cause codes, interrupt indices, mstatus fields and FSM states
// shared by the trap sequencer and its interrupt priority encoder.
package trap_ctrl_pkg;
    localparam int XLEN = 64;
    localparam int ALEN = 64;
    localparam int INTR_LEN = 32;
    localparam int IDX_W = $clog2(INTR_LEN);

    localparam logic [1:0] PRIV_USER = 2'b00;
    localparam logic [1:0] PRIV_MACHINE = 2'b11;

    localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    localparam int MSI = 3;
    localparam int MTI = 7;
    localparam int MEI = 11;
    localparam int PLATFORM_BASE = 16;

    localparam int MSTATUS_MIE = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_TRAP = 3'd2;
    localparam logic [2:0] ST_XRET = 3'd3;
    localparam logic [2:0] ST_XRET_DONE = 3'd4;
    localparam logic [2:0] ST_REDIRECT = 3'd5;

    typedef enum logic [2:0] {
        TS_IDLE = ST_IDLE,
        TS_DRAIN = ST_DRAIN,
        TS_TRAP = ST_TRAP,
        TS_XRET = ST_XRET,
        TS_XRET_DONE = ST_XRET_DONE,
        TS_REDIRECT = ST_REDIRECT
    } trap_state_e;

    // Vectored mode only applies to interrupts; exceptions always land on the base.
    function automatic logic [ALEN-1:0] handler_pc(input logic [XLEN-1:0] tvec, input logic intr,
                                                   input logic [IDX_W-1:0] idx);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        handler_pc = ALEN'(base + ((tvec[1:0] == 2'b01 && intr) ? XLEN'({idx, 2'b00}) : '0));
    endfunction
endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// intr_prio_enc: picks the highest-priority pending interrupt (MEI, MSI, MTI, then platform
// lines lowest index first); other low bits are not interrupt sources here.
module intr_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [INTR_LEN-1:0] pend,
    output logic                valid,
    output logic [IDX_W-1:0]    index
);
    localparam logic [INTR_LEN-1:0] RANKED = (INTR_LEN'(1) << MSI) | (INTR_LEN'(1) << MTI) |
                                             (INTR_LEN'(1) << MEI) | ({INTR_LEN{1'b1}} << PLATFORM_BASE);

    logic [INTR_LEN-1:0] ranked;

    assign ranked = pend & RANKED;
    assign valid = |ranked;

    always_comb begin
        index = '0;
        for (int i = INTR_LEN - 1; i >= PLATFORM_BASE; i--) index = ranked[i] ? IDX_W'(i) : index;
        index = ranked[MTI] ? IDX_W'(MTI) : index;
        index = ranked[MSI] ? IDX_W'(MSI) : index;
        index = ranked[MEI] ? IDX_W'(MEI) : index;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exception/interrupt entry and MRET between exec and the CSR file:
// capture, drain the pipeline, pulse the CSR update, then redirect fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic HANDLER_ALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exc_valid,
    input  logic [3:0]          exc_cause,
    input  logic [ALEN-1:0]     exc_pc,
    input  logic [XLEN-1:0]     exc_tval,
    input  logic                mret_valid,
    input  logic [ALEN-1:0]     next_pc,
    input  logic                pipeline_idle,
    input  logic [1:0]          privilege_mode,
    input  logic [XLEN-1:0]     mstatus,
    input  logic [INTR_LEN-1:0] mie,
    input  logic [INTR_LEN-1:0] mip,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [ALEN-1:0]     mepc,
    output logic                stall_issue,
    output logic                flush,
    output logic                trap_ack,
    output logic                trap_do_update,
    output logic [XLEN-1:0]     trap_mcause,
    output logic [ALEN-1:0]     trap_mepc,
    output logic [XLEN-1:0]     trap_mtval,
    output logic                xret_do_update,
    output logic                xret_completing,
    output logic [XLEN-1:0]     xret_new_mstatus,
    output logic [1:0]          xret_new_privilege_mode,
    output logic                redirect_valid,
    output logic [ALEN-1:0]     redirect_pc
);
    logic [2:0]          state;
    logic                drain_first;
    logic                is_mret;
    logic [XLEN-1:0]     cap_mcause;
    logic [ALEN-1:0]     cap_mepc;
    logic [XLEN-1:0]     cap_mtval;
    logic [ALEN-1:0]     target;
    logic                int_en;
    logic                pend_valid;
    logic [IDX_W-1:0]    pend_idx;
    logic                take_intr;
    logic                done_intr;
    logic [XLEN-1:0]     intr_mcause;
    logic                in_trap;

    intr_prio_enc u_prio (
        .pend  (mip & mie),
        .valid (pend_valid),
        .index (pend_idx)
    );

    assign int_en = (privilege_mode < PRIV_MACHINE) || mstatus[MSTATUS_MIE];
    assign take_intr = int_en && pend_valid;
    assign intr_mcause = {1'b1, {(XLEN - 1 - IDX_W){1'b0}}, pend_idx};
    // After MRET the CSRs already hold the restored MIE/privilege, so a pending interrupt is
    // taken directly; mepc is left alone because it already equals the return address.
    assign done_intr = (state == ST_XRET_DONE) && take_intr;
    assign in_trap = state == ST_TRAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            drain_first <= 1'b0;
            is_mret <= 1'b0;
            cap_mcause <= '0;
            cap_mepc <= '0;
            cap_mtval <= '0;
            target <= '0;
        end else begin
            drain_first <= 1'b0;
            case (state)
                ST_IDLE: if (exc_valid || mret_valid || take_intr) begin
                    state <= ST_DRAIN;
                    drain_first <= 1'b1;
                    is_mret <= !exc_valid && mret_valid;
                    cap_mcause <= exc_valid ? XLEN'(exc_cause) : mret_valid ? '0 : intr_mcause;
                    cap_mepc <= exc_valid ? exc_pc : mret_valid ? '0 : next_pc;
                    cap_mtval <= exc_valid ? exc_tval : '0;
                    target <= handler_pc(mtvec, !exc_valid, pend_idx);
                end
                ST_DRAIN: state <= pipeline_idle ? (is_mret ? ST_XRET : ST_TRAP) : ST_DRAIN;
                ST_TRAP: state <= ST_REDIRECT;
                ST_XRET: state <= ST_XRET_DONE;
                ST_XRET_DONE: begin
                    state <= ST_REDIRECT;
                    target <= take_intr ? handler_pc(mtvec, 1'b1, pend_idx) : mepc;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall_issue = state != ST_IDLE;
    assign flush = (state == ST_DRAIN) && drain_first;
    assign redirect_valid = state == ST_REDIRECT;
    assign trap_ack = redirect_valid;
    assign redirect_pc = redirect_valid ? {target[ALEN-1:1], target[0] & ~HANDLER_ALIGN_CHECK} : '0;
    assign trap_do_update = in_trap || done_intr;
    assign trap_mcause = in_trap ? cap_mcause : done_intr ? intr_mcause : '0;
    assign trap_mepc = in_trap ? cap_mepc : done_intr ? mepc : '0;
    assign trap_mtval = in_trap ? cap_mtval : '0;
    assign xret_do_update = state == ST_XRET;
    assign xret_completing = state == ST_XRET_DONE;
    assign xret_new_privilege_mode = xret_do_update ? mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : 2'b00;

    always_comb begin
        xret_new_mstatus = '0;
        if (xret_do_update) begin
            xret_new_mstatus = mstatus;
            xret_new_mstatus[MSTATUS_MIE] = mstatus[MSTATUS_MPIE];
            xret_new_mstatus[MSTATUS_MPIE] = 1'b1;
            xret_new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end
    end
endmodule
